// File: rtl/order_message_parser.sv
// order_message_parser
// Parses framed order messages arriving one word per transfer on a
// valid/ready stream. Each message is a header word (length, opcode, stock),
// an order-ID word, a price/quantity word and optional padding. A good message
// is presented on a held valid/ready output until it is accepted. Malformed
// framing raises a one-cycle error pulse, and any unread words of the bad
// message are discarded.
//
// Ports
//   clk_in, reset_n_in   clock (rising edge), asynchronous active-low reset
//   enable_in            allows a new header to be accepted while idle
//   data_in/_valid_in/_last_in, data_ready_out   input word stream
//   msg_valid_out, msg_ready_in                  decoded message handshake
//   operation_out, stock_symbol_out, order_id_out, price_out, quantity_out
//   err_valid_out, err_code_out   01 bad length, 10 truncated, 11 overrun
//   msg_count_out, err_count_out  saturating statistics counters
module order_message_parser #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned PRICE_WIDTH = 16,
   parameter int unsigned QUANT_WIDTH = 8,
   parameter int unsigned ID_WIDTH    = 16,
   parameter int unsigned STOCK_WIDTH = 8,
   parameter int unsigned MAX_WORDS   = 16,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                   clk_in,
   input  logic                   reset_n_in,
   input  logic                   enable_in,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   data_valid_in,
   input  logic                   data_last_in,
   output logic                   data_ready_out,
   output logic                   msg_valid_out,
   input  logic                   msg_ready_in,
   output logic [2:0]             operation_out,
   output logic [STOCK_WIDTH-1:0] stock_symbol_out,
   output logic [ID_WIDTH-1:0]    order_id_out,
   output logic [PRICE_WIDTH-1:0] price_out,
   output logic [QUANT_WIDTH-1:0] quantity_out,
   output logic                   err_valid_out,
   output logic [1:0]             err_code_out,
   output logic [CNT_WIDTH-1:0]   msg_count_out,
   output logic [CNT_WIDTH-1:0]   err_count_out
);

   localparam logic [7:0] LP_MIN_LEN = 8'd3;
   localparam logic [7:0] LP_MAX_LEN = 8'(MAX_WORDS);

   localparam logic [1:0] LP_ERR_LEN   = 2'b01;
   localparam logic [1:0] LP_ERR_TRUNC = 2'b10;
   localparam logic [1:0] LP_ERR_OVER  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BODY  = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [7:0]             r_remain;
   logic [7:0]             r_widx;
   logic [2:0]             r_op_sh;
   logic [STOCK_WIDTH-1:0] r_stock_sh;
   logic [ID_WIDTH-1:0]    r_id_sh;
   logic [PRICE_WIDTH-1:0] r_price_sh;
   logic [QUANT_WIDTH-1:0] r_qty_sh;

   logic [2:0]             r_op;
   logic [STOCK_WIDTH-1:0] r_stock;
   logic [ID_WIDTH-1:0]    r_id;
   logic [PRICE_WIDTH-1:0] r_price;
   logic [QUANT_WIDTH-1:0] r_qty;
   logic                   r_err_valid;
   logic [1:0]             r_err_code;
   logic [CNT_WIDTH-1:0]   r_msg_cnt;
   logic [CNT_WIDTH-1:0]   r_err_cnt;

   logic       w_ready;
   logic       w_xfer;
   logic [7:0] w_len;
   logic       w_len_ok;
   logic       w_err_set;
   logic [1:0] w_err_code;
   logic       w_hdr_load;
   logic       w_body_step;
   logic       w_out_load;
   logic       w_unused;

   // Header field decode and word-transfer qualifier.
   assign w_len    = data_in[7:0];
   assign w_len_ok = (w_len >= LP_MIN_LEN) && (w_len <= LP_MAX_LEN);
   assign w_xfer   = data_valid_in & data_ready_out;
   assign w_unused = ^data_in;

   // Ready is decoded from state; it is forced low while reset is held.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_IDLE:  w_ready = enable_in;
         S_BODY:  w_ready = 1'b1;
         S_DRAIN: w_ready = 1'b1;
         S_HOLD:  w_ready = 1'b0;
         default: w_ready = 1'b0;
      endcase
   end

   assign data_ready_out = reset_n_in & w_ready;

   // State register.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) r_state <= S_IDLE;
      else             r_state <= w_state_nxt;
   end

   // Next-state and per-transfer control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_err_set   = 1'b0;
      w_err_code  = 2'b00;
      w_hdr_load  = 1'b0;
      w_body_step = 1'b0;
      w_out_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               if (!w_len_ok) begin
                  w_err_set   = 1'b1;
                  w_err_code  = LP_ERR_LEN;
                  w_state_nxt = data_last_in ? S_IDLE : S_DRAIN;
               end else if (data_last_in) begin
                  w_err_set  = 1'b1;
                  w_err_code = LP_ERR_TRUNC;
               end else begin
                  w_hdr_load  = 1'b1;
                  w_state_nxt = S_BODY;
               end
            end
         end
         S_BODY: begin
            if (w_xfer) begin
               if (r_remain == 8'd1) begin
                  if (data_last_in) begin
                     w_out_load  = 1'b1;
                     w_state_nxt = S_HOLD;
                  end else begin
                     w_err_set   = 1'b1;
                     w_err_code  = LP_ERR_OVER;
                     w_state_nxt = S_DRAIN;
                  end
               end else if (data_last_in) begin
                  w_err_set   = 1'b1;
                  w_err_code  = LP_ERR_TRUNC;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_body_step = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (w_xfer && data_last_in) w_state_nxt = S_IDLE;
         end
         S_HOLD: begin
            if (msg_ready_in) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Working registers: word position, remaining count and shadow fields.
   // Fields collect here so a message that later fails leaves the outputs alone.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_remain   <= 8'd0;
         r_widx     <= 8'd0;
         r_op_sh    <= 3'd0;
         r_stock_sh <= '0;
         r_id_sh    <= '0;
         r_price_sh <= '0;
         r_qty_sh   <= '0;
      end else begin
         if (w_hdr_load) begin
            r_remain   <= 8'(w_len - 8'd1);
            r_widx     <= 8'd1;
            r_op_sh    <= data_in[10:8];
            r_stock_sh <= data_in[16 +: STOCK_WIDTH];
         end else if (w_body_step) begin
            r_remain <= r_remain - 8'd1;
            r_widx   <= r_widx + 8'd1;
         end
         if ((r_state == S_BODY) && w_xfer) begin
            if (r_widx == 8'd1) r_id_sh <= data_in[ID_WIDTH-1:0];
            if (r_widx == 8'd2) begin
               r_price_sh <= data_in[PRICE_WIDTH-1:0];
               r_qty_sh   <= data_in[DATA_WIDTH-1 -: QUANT_WIDTH];
            end
         end
      end
   end

   // Output fields load only on a good final word; a three-word message
   // ends on the price word, so that word bypasses the shadow.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_op    <= 3'd0;
         r_stock <= '0;
         r_id    <= '0;
         r_price <= '0;
         r_qty   <= '0;
      end else if (w_out_load) begin
         r_op    <= r_op_sh;
         r_stock <= r_stock_sh;
         r_id    <= r_id_sh;
         if (r_widx == 8'd2) begin
            r_price <= data_in[PRICE_WIDTH-1:0];
            r_qty   <= data_in[DATA_WIDTH-1 -: QUANT_WIDTH];
         end else begin
            r_price <= r_price_sh;
            r_qty   <= r_qty_sh;
         end
      end
   end

   // Error pulse and saturating statistics counters.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_err_valid <= 1'b0;
         r_err_code  <= 2'b00;
         r_msg_cnt   <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_err_valid <= w_err_set;
         r_err_code  <= w_err_code;
         if (w_err_set && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
         if ((r_state == S_HOLD) && msg_ready_in && (r_msg_cnt != '1))
            r_msg_cnt <= r_msg_cnt + CNT_WIDTH'(1);
      end
   end

   assign msg_valid_out    = (r_state == S_HOLD);
   assign operation_out    = r_op;
   assign stock_symbol_out = r_stock;
   assign order_id_out     = r_id;
   assign price_out        = r_price;
   assign quantity_out     = r_qty;
   assign err_valid_out    = r_err_valid;
   assign err_code_out     = r_err_code;
   assign msg_count_out    = r_msg_cnt;
   assign err_count_out    = r_err_cnt;

endmodule

// File: tb/tb_order_message_parser.sv
// Bench for order_message_parser: directed framing scenarios followed by random
// packets. Each packet's outcome is predicted from its header length and
// word count, then pushed to a queue. A negedge monitor checks every
// message, error pulse and counter value against those queues.
module tb_order_message_parser;

   localparam int unsigned DW   = 32;
   localparam int unsigned MAXW = 16;
   localparam int unsigned CW   = 4;

   logic          clk_in = 1'b0;
   logic          reset_n_in;
   logic          enable_in;
   logic [DW-1:0] data_in;
   logic          data_valid_in;
   logic          data_last_in;
   logic          data_ready_out;
   logic          msg_valid_out;
   logic          msg_ready_in;
   logic [2:0]    operation_out;
   logic [7:0]    stock_symbol_out;
   logic [15:0]   order_id_out;
   logic [15:0]   price_out;
   logic [7:0]    quantity_out;
   logic          err_valid_out;
   logic [1:0]    err_code_out;
   logic [CW-1:0] msg_count_out;
   logic [CW-1:0] err_count_out;

   always #5 clk_in = ~clk_in;

   order_message_parser #(
      .DATA_WIDTH(DW), .PRICE_WIDTH(16), .QUANT_WIDTH(8), .ID_WIDTH(16),
      .STOCK_WIDTH(8), .MAX_WORDS(MAXW), .CNT_WIDTH(CW)
   ) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
      .data_in(data_in), .data_valid_in(data_valid_in), .data_last_in(data_last_in),
      .data_ready_out(data_ready_out), .msg_valid_out(msg_valid_out),
      .msg_ready_in(msg_ready_in), .operation_out(operation_out),
      .stock_symbol_out(stock_symbol_out), .order_id_out(order_id_out),
      .price_out(price_out), .quantity_out(quantity_out),
      .err_valid_out(err_valid_out), .err_code_out(err_code_out),
      .msg_count_out(msg_count_out), .err_count_out(err_count_out)
   );

   typedef struct packed {
      logic [2:0]  op;
      logic [7:0]  stock;
      logic [15:0] id;
      logic [15:0] price;
      logic [7:0]  qty;
   } msg_t;

   msg_t       msg_q[$];
   logic [1:0] err_q[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   bit         rand_ctrl = 1'b0;

   logic [31:0] pkt[0:31];
   int          pkt_n;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] hdr(input int len, input int op, input logic [7:0] stock);
      logic [31:0] w;
      w        = 32'h0;
      w[7:0]   = 8'(len);
      w[10:8]  = 3'(op);
      w[23:16] = stock;
      return w;
   endfunction

   function automatic logic [31:0] w2(input logic [15:0] price, input logic [7:0] qty);
      return {qty, 8'h00, price};
   endfunction

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   // Outcome of a whole packet: length range, then word count versus length.
   task automatic predict();
      int   len;
      msg_t m;
      len = int'(pkt[0][7:0]);
      if (len < 3 || len > int'(MAXW)) err_q.push_back(2'b01);
      else if (pkt_n < len)            err_q.push_back(2'b10);
      else if (pkt_n > len)            err_q.push_back(2'b11);
      else begin
         m.op    = pkt[0][10:8];
         m.stock = pkt[0][23:16];
         m.id    = pkt[1][15:0];
         m.price = pkt[2][15:0];
         m.qty   = pkt[2][31:24];
         msg_q.push_back(m);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit last);
      bit rdy;
      int t;
      data_in       = w;
      data_valid_in = 1'b1;
      data_last_in  = last;
      rdy = 1'b0;
      t   = 0;
      while (!rdy) begin
         @(negedge clk_in);
         rdy = data_ready_out;
         @(posedge clk_in);
         #1;
         t++;
         if (!rdy && t > 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 300 cycles at %0t", $time);
            break;
         end
      end
      data_valid_in = 1'b0;
      data_last_in  = 1'b0;
      data_in       = $urandom;
   endtask

   task automatic send_pkt();
      predict();
      for (int i = 0; i < pkt_n; i++) begin
         send_word(pkt[i], i == pkt_n - 1);
         if (rand_ctrl && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk_in); #1; end
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk_in); #1; end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, data_ready_out, 0);
      chk({tag, "_valid"}, msg_valid_out, 0);
      chk({tag, "_fields"}, {operation_out, stock_symbol_out, order_id_out, price_out, quantity_out}, 0);
      chk({tag, "_err"}, {err_valid_out, err_code_out}, 0);
      chk({tag, "_counts"}, {msg_count_out, err_count_out}, 0);
   endtask

   // Background randomisation of the downstream ready and the header enable.
   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         if (rand_ctrl) begin
            msg_ready_in = 1'($urandom_range(0, 1));
            enable_in    = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: scoreboard pops, latency, hold stability and counter tracking.
   logic [CW-1:0] exp_msg_cnt, exp_err_cnt;
   bit            prev_xfer, prev_last, prev_valid, prev_hs;
   msg_t          held;

   always @(negedge clk_in) begin
      msg_t act;
      if (!reset_n_in) begin
         exp_msg_cnt = '0;
         exp_err_cnt = '0;
         prev_xfer   = 1'b0;
         prev_last   = 1'b0;
         prev_valid  = 1'b0;
         prev_hs     = 1'b0;
      end else begin
         act = {operation_out, stock_symbol_out, order_id_out, price_out, quantity_out};
         if (prev_hs) begin
            exp_msg_cnt = sat(exp_msg_cnt);
            chk("msg_released", msg_valid_out, 0);
         end
         if (err_valid_out) begin
            chk("err_latency", prev_xfer, 1);
            if (err_q.size() == 0) chk("err_unexpected", {err_valid_out, err_code_out}, 0);
            else                   chk("err_code", err_code_out, err_q.pop_front());
            exp_err_cnt = sat(exp_err_cnt);
         end
         if (msg_valid_out && !prev_valid) begin
            chk("msg_latency", prev_last, 1);
            if (msg_q.size() == 0) chk("msg_unexpected", msg_valid_out, 0);
            else begin
               held = msg_q.pop_front();
               chk("msg_fields", act, held);
            end
         end else if (msg_valid_out) begin
            chk("msg_stable", act, held);
         end
         if (msg_valid_out) chk("ready_in_hold", data_ready_out, 0);
         chk("msg_count", msg_count_out, exp_msg_cnt);
         chk("err_count", err_count_out, exp_err_cnt);
         prev_xfer  = data_valid_in && data_ready_out;
         prev_last  = prev_xfer && data_last_in;
         prev_valid = msg_valid_out;
         prev_hs    = msg_valid_out && msg_ready_in;
      end
   end

   initial begin
      int len;
      int t;
      reset_n_in    = 1'b0;
      enable_in     = 1'b1;
      data_in       = '0;
      data_valid_in = 1'b0;
      data_last_in  = 1'b0;
      msg_ready_in  = 1'b1;
      #1;
      chk_all_zero("reset_init");
      @(posedge clk_in); @(posedge clk_in); #1;
      reset_n_in = 1'b1;
      idle_cycles(1);

      // Basic three-word message.
      pkt_n  = 3;
      pkt[0] = hdr(3, 2, 8'h41);
      pkt[1] = 32'h0000_1234;
      pkt[2] = w2(16'h00C8, 8'h05);
      send_pkt();
      @(negedge clk_in);
      chk("basic_valid", msg_valid_out, 1);
      chk("basic_fields", {operation_out, stock_symbol_out, order_id_out, price_out, quantity_out},
          {3'd2, 8'h41, 16'h1234, 16'h00C8, 8'h05});
      @(negedge clk_in);
      chk("basic_msg_count", msg_count_out, 1);
      idle_cycles(1);

      // Length below minimum, trailing word drained.
      pkt_n  = 2;
      pkt[0] = hdr(2, 1, 8'h33);
      pkt[1] = 32'hDEAD_BEEF;
      send_pkt();
      idle_cycles(2);
      chk("badlen_err_count", err_count_out, 1);
      chk("badlen_no_msg", msg_count_out, 1);

      // Truncated five-word message, then a good four-word message.
      pkt_n  = 3;
      pkt[0] = hdr(5, 3, 8'h22);
      pkt[1] = 32'h0000_5555;
      pkt[2] = w2(16'h7777, 8'h66);
      send_pkt();
      pkt_n  = 4;
      pkt[0] = hdr(4, 5, 8'h7E);
      pkt[1] = 32'h0000_BEEF;
      pkt[2] = w2(16'h1111, 8'h99);
      pkt[3] = 32'hFFFF_FFFF;
      send_pkt();
      idle_cycles(2);
      chk("trunc_then_good_counts", {msg_count_out, err_count_out}, {4'd2, 4'd2});

      // Overrun: last absent on the final word, two words drained.
      pkt_n  = 5;
      pkt[0] = hdr(3, 1, 8'h10);
      pkt[1] = 32'h0000_0A0A;
      pkt[2] = w2(16'h0B0B, 8'h0C);
      pkt[3] = 32'h1234_5678;
      pkt[4] = 32'h8765_4321;
      send_pkt();
      idle_cycles(2);
      chk("overrun_err_count", err_count_out, 3);

      // Downstream back-pressure holds the message.
      msg_ready_in = 1'b0;
      pkt_n  = 3;
      pkt[0] = hdr(3, 6, 8'hA5);
      pkt[1] = 32'h0000_4242;
      pkt[2] = w2(16'hFFFF, 8'hFF);
      send_pkt();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         chk("hold_valid", msg_valid_out, 1);
         chk("hold_ready_low", data_ready_out, 0);
      end
      @(posedge clk_in); #1;
      msg_ready_in = 1'b1;
      @(posedge clk_in); #1;
      chk("hold_released", msg_valid_out, 0);
      idle_cycles(3);

      // Asynchronous reset in the middle of a message.
      send_word(hdr(4, 7, 8'h5A), 1'b0);
      send_word(32'h0000_9999, 1'b0);
      #2;
      reset_n_in = 1'b0;
      #1;
      chk_all_zero("reset_mid");
      @(posedge clk_in); @(posedge clk_in); #1;
      reset_n_in = 1'b1;
      pkt_n  = 3;
      pkt[0] = hdr(3, 4, 8'h19);
      pkt[1] = 32'h0000_CAFE;
      pkt[2] = w2(16'h0102, 8'h03);
      send_pkt();
      idle_cycles(2);
      chk("post_reset_counts", {msg_count_out, err_count_out}, {4'd1, 4'd0});

      // Random packets; counters are narrow so saturation is exercised.
      rand_ctrl = 1'b1;
      for (int p = 0; p < 300; p++) begin
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(3, MAXW));
         if (len < 3)                          pkt_n = int'($urandom_range(1, 4));
         else if ($urandom_range(0, 2) != 0)   pkt_n = len;
         else                                  pkt_n = int'($urandom_range(1, len + 3));
         for (int i = 0; i < 32; i++) pkt[i] = $urandom;
         pkt[0][7:0] = 8'(len);
         send_pkt();
      end
      rand_ctrl    = 1'b0;
      msg_ready_in = 1'b1;
      enable_in    = 1'b1;
      t = 0;
      while ((msg_q.size() + err_q.size()) != 0 && t < 200) begin
         idle_cycles(1);
         t++;
      end
      idle_cycles(3);
      chk("queues_drained", 64'(msg_q.size() + err_q.size()), 0);
      chk("final_counts", {msg_count_out, err_count_out}, {exp_msg_cnt, exp_err_cnt});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/order_message_parser.md
ORDER_MESSAGE_PARSER -- requirements
Module: order_message_parser

Interface
REQ-001 Parameter DATA_WIDTH, 32, input word width; SHALL be >= 16+STOCK_WIDTH.
REQ-002 Parameter PRICE_WIDTH, 16, price field width; PRICE_WIDTH+QUANT_WIDTH SHALL be <= DATA_WIDTH.
REQ-003 Parameter QUANT_WIDTH, 8, quantity field width.
REQ-004 Parameter ID_WIDTH, 16, order ID width; SHALL be <= DATA_WIDTH.
REQ-005 Parameter STOCK_WIDTH, 8, stock symbol width.
REQ-006 Parameter MAX_WORDS, 16, maximum legal message length in words (3..255).
REQ-007 Parameter CNT_WIDTH, 16, statistics counter width.
REQ-008 Ports SHALL be exactly (name  direction  width  meaning):
- clk_in  input  1  single clock, rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- enable_in  input  1  permits acceptance of a new header
- data_in  input  DATA_WIDTH  message word
- data_valid_in  input  1  data_in valid
- data_last_in  input  1  marks final word of a message
- data_ready_out  output  1  parser can accept a word
- msg_valid_out  output  1  decoded message available
- msg_ready_in  input  1  downstream accepts message
- operation_out  output  3  opcode
- stock_symbol_out  output  STOCK_WIDTH  stock symbol
- order_id_out  output  ID_WIDTH  order ID
- price_out  output  PRICE_WIDTH  price
- quantity_out  output  QUANT_WIDTH  quantity
- err_valid_out  output  1  one-cycle error pulse
- err_code_out  output  2  01 bad length, 10 truncated, 11 overrun
- msg_count_out  output  CNT_WIDTH  messages delivered
- err_count_out  output  CNT_WIDTH  errors flagged

Function
REQ-009 Transfer SHALL occur on a rising edge with data_valid_in=1 and data_ready_out=1; no other cycle consumes a word.
REQ-010 Message format SHALL be: word0 header = len[7:0], opcode[10:8], stock[16+:STOCK_WIDTH]; word1 order_id[ID_WIDTH-1:0]; word2 price[PRICE_WIDTH-1:0], quantity[DATA_WIDTH-1 -: QUANT_WIDTH]; words 3..len-1 padding, discarded.
REQ-011 FSM states SHALL be IDLE, BODY, DRAIN, HOLD; data_ready_out = enable_in in IDLE, 1 in BODY/DRAIN, 0 in HOLD (combinational from state).
REQ-012 IDLE, header transfer with len<3 or len>MAX_WORDS: error 01; next state DRAIN if data_last_in=0, else IDLE.
REQ-013 IDLE, legal header with data_last_in=1: error 10, stay IDLE.
REQ-014 IDLE, legal header with data_last_in=0: capture opcode and stock, remaining count = len-1, go BODY.
REQ-015 BODY: each transfer decrements remaining; word1 and word2 fields captured per REQ-010; padding ignored.
REQ-016 BODY, non-final word with data_last_in=1: error 10, go IDLE, no message delivered.
REQ-017 BODY, final word (remaining=1) with data_last_in=1: go HOLD; with data_last_in=0: error 11, go DRAIN.
REQ-018 DRAIN: discard words until a transfer with data_last_in=1, then IDLE; no further error.
REQ-019 HOLD: msg_valid_out=1, rising the cycle after the final-word transfer (latency 1); field outputs SHALL NOT change while msg_valid_out=1.
REQ-020 HOLD with msg_ready_in=1 at an edge: msg_valid_out=0 and state IDLE next cycle; msg_count_out increments.
REQ-021 err_valid_out/err_code_out SHALL be registered, high exactly one cycle after the offending transfer; err_count_out increments same edge.
REQ-022 Both counters SHALL saturate at all-ones, never wrap.
REQ-023 enable_in SHALL affect only IDLE; deassertion mid-message SHALL NOT stall or abort parsing.
REQ-024 Field outputs are meaningful only while msg_valid_out=1; after errors they retain prior values.

Reset
REQ-025 reset_n_in=0 SHALL immediately (no clock) force state IDLE, all outputs and counters to 0, data_ready_out=0.
REQ-026 Reset mid-message SHALL discard the partial message without error; after release, the first edge with enable_in=1 accepts a header.

Verification
REQ-027 Header len=3 op=2 stock=0x41, word1=0x1234, word2 price=0x00C8 qty=0x05 last -> msg_valid_out next cycle, outputs 2/0x41/0x1234/0x00C8/0x05, msg_count=1.
REQ-028 Header len=2 with last=0 then one word with last -> err 01 one cycle, second word drained, err_count=1, no message.
REQ-029 len=5 header, last asserted on word2 -> err 10, IDLE; next valid message decodes correctly.
REQ-030 len=3 message, last absent on word2, two further words, last on second -> err 11, both drained, IDLE.
REQ-031 Message complete, msg_ready_in=0 for 4 cycles -> msg_valid_out held, data_ready_out=0, fields stable; msg_ready_in=1 -> released next cycle.
REQ-032 reset_n_in pulsed low after word1 of len=4 message -> outputs 0 asynchronously; subsequent len=3 message decodes, err_count=0.
